// File: rtl/frame_readout_ctrl.sv
// Streams a decimated frame out of a single-line buffer to a UART, one or two
// bytes per pixel, under control of a one-byte command interface.
module frame_readout_ctrl #(
    parameter int H     = 752,
    parameter int V     = 480,
    parameter int PIX_W = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VALID,
    input  logic [7:0]           CMD_DATA,
    input  logic                 WHOLE_LINE_READY_FLAG,
    input  logic [PIX_W-1:0]     DATA_IN,
    input  logic                 TX_IDLE,
    output logic [$clog2(V)-1:0] INTERESTING_LINE,
    output logic [$clog2(H)-1:0] READ_ADDRESS,
    output logic                 RESET_READY_FLAG,
    output logic [7:0]           TX_DATA,
    output logic                 TX_DATA_READY,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int HW = $clog2(H);
    localparam int VW = $clog2(V);
    localparam int CW = HW + 4;
    localparam int LW = VW + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_FETCH,
        S_SEND_HI,
        S_SEND_LO,
        S_WAIT_TX
    } state_t;

    state_t           state;
    logic [1:0]       dec;
    logic             wide;
    logic             lo_pending;
    logic             fetch_wait;
    logic [PIX_W-1:0] pixel;

    logic [3:0]    step;
    logic [CW-1:0] col_next;
    logic [LW-1:0] line_next;
    logic          col_wrap;
    logic          frame_end;
    logic [15:0]   pix_ext;
    logic [15:0]   din_ext;
    logic [7:0]    hi_byte;
    logic [7:0]    lo_byte;
    logic          cmd_abort;
    logic          cmd_start;

    always_comb begin
        step      = 4'd1 << dec;
        col_next  = CW'(READ_ADDRESS) + CW'(step);
        line_next = LW'(INTERESTING_LINE) + LW'(step);
        col_wrap  = col_next >= CW'(H);
        frame_end = line_next >= LW'(V);
        pix_ext   = 16'(pixel);
        din_ext   = 16'(DATA_IN);
        // Shifting a zero-extended copy gives pixel[PIX_W-1:8] (0 when PIX_W=8)
        hi_byte   = wide ? 8'(pix_ext >> 8) : 8'(din_ext >> (PIX_W - 8));
        lo_byte   = pix_ext[7:0];
        cmd_abort = CMD_VALID && (CMD_DATA == 8'h00);
        cmd_start = CMD_VALID && CMD_DATA[7];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= S_IDLE;
            dec              <= '0;
            wide             <= 1'b0;
            lo_pending       <= 1'b0;
            fetch_wait       <= 1'b0;
            pixel            <= '0;
            INTERESTING_LINE <= '0;
            READ_ADDRESS     <= '0;
            RESET_READY_FLAG <= 1'b1;
            TX_DATA          <= '0;
            TX_DATA_READY    <= 1'b0;
            BUSY             <= 1'b0;
            FRAME_DONE       <= 1'b0;
        end else begin
            TX_DATA_READY    <= 1'b0;
            FRAME_DONE       <= 1'b0;
            RESET_READY_FLAG <= 1'b0;
            if (state != S_IDLE && cmd_abort) begin
                state            <= S_IDLE;
                INTERESTING_LINE <= '0;
                READ_ADDRESS     <= '0;
                lo_pending       <= 1'b0;
                fetch_wait       <= 1'b0;
                BUSY             <= 1'b0;
                RESET_READY_FLAG <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_start) begin
                            dec              <= CMD_DATA[1:0];
                            wide             <= CMD_DATA[2];
                            INTERESTING_LINE <= '0;
                            READ_ADDRESS     <= '0;
                            BUSY             <= 1'b1;
                            state            <= S_WAIT_LINE;
                        end else begin
                            RESET_READY_FLAG <= 1'b1;
                        end
                    end
                    S_WAIT_LINE: begin
                        // The ready flag is stale while our clear pulse is still out
                        if (WHOLE_LINE_READY_FLAG && !RESET_READY_FLAG) begin
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // After a column step, give the buffer one cycle for the new address
                        if (fetch_wait) begin
                            fetch_wait <= 1'b0;
                        end else begin
                            pixel <= DATA_IN;
                            state <= S_SEND_HI;
                        end
                    end
                    S_SEND_HI: begin
                        if (TX_IDLE) begin
                            TX_DATA       <= hi_byte;
                            TX_DATA_READY <= 1'b1;
                            lo_pending    <= wide;
                            state         <= S_WAIT_TX;
                        end
                    end
                    S_SEND_LO: begin
                        if (TX_IDLE) begin
                            TX_DATA       <= lo_byte;
                            TX_DATA_READY <= 1'b1;
                            lo_pending    <= 1'b0;
                            state         <= S_WAIT_TX;
                        end
                    end
                    S_WAIT_TX: begin
                        // TX_IDLE lags our strobe by a cycle, so skip the strobe cycle
                        if (!TX_DATA_READY && TX_IDLE) begin
                            if (lo_pending) begin
                                state <= S_SEND_LO;
                            end else if (col_wrap) begin
                                READ_ADDRESS <= '0;
                                if (frame_end) begin
                                    INTERESTING_LINE <= '0;
                                    FRAME_DONE       <= 1'b1;
                                    BUSY             <= 1'b0;
                                    RESET_READY_FLAG <= 1'b1;
                                    state            <= S_IDLE;
                                end else begin
                                    INTERESTING_LINE <= line_next[VW-1:0];
                                    RESET_READY_FLAG <= 1'b1;
                                    state            <= S_WAIT_LINE;
                                end
                            end else begin
                                READ_ADDRESS <= col_next[HW-1:0];
                                fetch_wait   <= 1'b1;
                                state        <= S_FETCH;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_readout_ctrl.sv
// Bench for frame_readout_ctrl: two instances (8x4 and 10x5) driven by line
// buffer and UART models; byte streams checked against a raster-order model.
module tb_frame_readout_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd_valid;
    logic [7:0] cmd_data;

    logic [1:0]       rdy;
    logic [1:0]       rdy_in;
    logic [1:0]       tx_idle;
    logic [1:0][9:0]  din;
    logic             rdy_force_hi;
    logic             rdy_force_lo;
    logic             tx_hold;
    logic             const_mode;
    int               seed;
    int               fill_cnt [2];
    int               tx_cnt [2];

    logic [1:0] a_il;
    logic [2:0] a_ra;
    logic [2:0] b_il;
    logic [3:0] b_ra;
    logic       a_rrf, b_rrf, a_txr, b_txr, a_busy, b_busy, a_fd, b_fd;
    logic [7:0] a_txd, b_txd;

    logic [1:0]      rrf, txr, busy, fd;
    logic [1:0][7:0] txd, line_o, col_o;

    int checks = 0;
    int errors = 0;

    frame_readout_ctrl #(.H(8), .V(4), .PIX_W(10)) u_a (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid[0]), .CMD_DATA(cmd_data),
        .WHOLE_LINE_READY_FLAG(rdy_in[0]), .DATA_IN(din[0]), .TX_IDLE(tx_idle[0]),
        .INTERESTING_LINE(a_il), .READ_ADDRESS(a_ra), .RESET_READY_FLAG(a_rrf),
        .TX_DATA(a_txd), .TX_DATA_READY(a_txr), .BUSY(a_busy), .FRAME_DONE(a_fd)
    );

    frame_readout_ctrl #(.H(10), .V(5), .PIX_W(10)) u_b (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid[1]), .CMD_DATA(cmd_data),
        .WHOLE_LINE_READY_FLAG(rdy_in[1]), .DATA_IN(din[1]), .TX_IDLE(tx_idle[1]),
        .INTERESTING_LINE(b_il), .READ_ADDRESS(b_ra), .RESET_READY_FLAG(b_rrf),
        .TX_DATA(b_txd), .TX_DATA_READY(b_txr), .BUSY(b_busy), .FRAME_DONE(b_fd)
    );

    assign rrf    = {b_rrf, a_rrf};
    assign txr    = {b_txr, a_txr};
    assign busy   = {b_busy, a_busy};
    assign fd     = {b_fd, a_fd};
    assign txd    = {b_txd, a_txd};
    assign line_o = {8'(b_il), 8'(a_il)};
    assign col_o  = {8'(b_ra), 8'(a_ra)};
    assign rdy_in = rdy_force_hi ? 2'b11 : (rdy_force_lo ? 2'b00 : rdy);
    assign tx_idle[0] = (tx_cnt[0] == 0) && !tx_hold;
    assign tx_idle[1] = (tx_cnt[1] == 0) && !tx_hold;

    always #5 clk = ~clk;

    function automatic logic [9:0] pixf(input logic [7:0] l, input logic [7:0] c);
        if (const_mode) return 10'h2A5;
        return 10'((int'(l) * 97 + int'(c) * 29 + seed) ^ (int'(l) << 6));
    endfunction

    // Line buffer: registered read data, fills a line some cycles after being cleared.
    // UART: goes busy for a random 0..4 cycles after each strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            din[i] <= pixf(line_o[i], col_o[i]);
            if (rst || rrf[i]) begin
                rdy[i]      <= 1'b0;
                fill_cnt[i] <= int'($urandom_range(0, 3));
            end else if (!rdy[i]) begin
                if (fill_cnt[i] == 0) rdy[i] <= 1'b1;
                else fill_cnt[i] <= fill_cnt[i] - 1;
            end
            if (rst) tx_cnt[i] <= 0;
            else if (txr[i]) tx_cnt[i] <= int'($urandom_range(0, 4));
            else if (tx_cnt[i] != 0) tx_cnt[i] <= tx_cnt[i] - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 full frame, 1 abort after 5th byte, 2 reset after 7th byte,
    //       3 line/UART stalls, 4 first-byte latency with ready flag forced high
    task automatic run_frame(input int inst, input logic [7:0] cmd, input int mode);
        int         hd, vd, step, idx, fd_cnt, rrf_pulses, exp_lines;
        logic       wide, done, prev_txr, busy_cmd_sent, abort_sent, rst_sent, hold_done;
        logic [9:0] p;
        logic [7:0] last_txd;
        logic [7:0] exp_q [$];

        hd = (inst == 0) ? 8 : 10;
        vd = (inst == 0) ? 4 : 5;
        step = 1 << cmd[1:0];
        wide = cmd[2];
        exp_lines = 0;
        for (int l = 0; l < vd; l += step) begin
            exp_lines++;
            for (int c = 0; c < hd; c += step) begin
                p = pixf(8'(l), 8'(c));
                if (wide) begin
                    exp_q.push_back(8'(p >> 8));
                    exp_q.push_back(p[7:0]);
                end else begin
                    exp_q.push_back(p[9:2]);
                end
            end
        end

        repeat (8) @(negedge clk);
        if (mode == 3) rdy_force_lo = 1'b1;
        if (mode == 4) rdy_force_hi = 1'b1;
        cmd_valid[inst] = 1'b1;
        cmd_data = cmd;
        @(negedge clk);
        cmd_valid = '0;
        chk("busy_after_start", busy[inst], 1);
        last_txd = txd[inst];

        if (mode == 3) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                chk("line_stall_busy", busy[inst], 1);
                chk("line_stall_no_strobe", txr[inst], 0);
            end
            rdy_force_lo = 1'b0;
        end

        idx = 0; fd_cnt = 0; rrf_pulses = 0; done = 0; prev_txr = 0;
        busy_cmd_sent = 0; abort_sent = 0; rst_sent = 0; hold_done = 0;
        for (int cyc = 1; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            if (abort_sent) begin
                cmd_valid = '0;
                chk("abort_busy_low", busy[inst], 0);
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    chk("abort_no_strobe", txr[inst], 0);
                    chk("abort_no_done", fd[inst], 0);
                end
                done = 1;
            end else if (rst_sent) begin
                rst = 1'b0;
                cmd_valid = '0;
                chk("rst_line", line_o[inst], 0);
                chk("rst_col", col_o[inst], 0);
                chk("rst_tx_data", txd[inst], 0);
                chk("rst_tx_ready", txr[inst], 0);
                chk("rst_busy", busy[inst], 0);
                chk("rst_frame_done", fd[inst], 0);
                chk("rst_ready_flag", rrf[inst], 1);
                @(negedge clk);
                chk("cmd_in_rst_ignored", busy[inst], 0);
                done = 1;
            end else begin
                cmd_valid = '0;
                if (txr[inst]) begin
                    chk("no_back_to_back", prev_txr, 0);
                    if (idx < exp_q.size()) chk($sformatf("byte%0d", idx), txd[inst], exp_q[idx]);
                    else chk("extra_byte", idx, exp_q.size());
                    if (mode == 4 && idx == 0) begin
                        chk("first_byte_latency", cyc, 3);
                        rdy_force_hi = 1'b0;
                    end
                    idx++;
                end else begin
                    chk("tx_data_hold", txd[inst], last_txd);
                end
                last_txd = txd[inst];
                prev_txr = txr[inst];
                if (rrf[inst] && busy[inst]) rrf_pulses++;
                if (fd[inst]) begin
                    fd_cnt++;
                    chk("busy_low_at_done", busy[inst], 0);
                    done = 1;
                end
                if (mode == 1 && idx == 2 && !busy_cmd_sent) begin
                    cmd_valid[inst] = 1'b1;
                    cmd_data = 8'h80;
                    busy_cmd_sent = 1;
                end else if (mode == 1 && idx == 5) begin
                    cmd_valid[inst] = 1'b1;
                    cmd_data = 8'h00;
                    abort_sent = 1;
                end
                if (mode == 2 && idx == 7) begin
                    rst = 1'b1;
                    cmd_valid[inst] = 1'b1;
                    cmd_data = 8'h80;
                    rst_sent = 1;
                end
                if (mode == 3 && idx == 1 && !hold_done) begin
                    tx_hold = 1'b1;
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk);
                        chk("tx_stall_no_strobe", txr[inst], 0);
                        chk("tx_stall_data_hold", txd[inst], last_txd);
                    end
                    tx_hold = 1'b0;
                    hold_done = 1;
                    prev_txr = 0;
                end
            end
        end

        if (mode == 0 || mode == 3 || mode == 4) begin
            chk("byte_count", idx, exp_q.size());
            chk("frame_done_count", fd_cnt, 1);
            chk("ready_clear_pulses", rrf_pulses, exp_lines - 1);
            @(negedge clk);
            chk("idle_busy", busy[inst], 0);
            chk("idle_ready_clear", rrf[inst], 1);
            chk("idle_line", line_o[inst], 0);
        end
        if (mode == 1) chk("bytes_before_abort", idx, 5);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = '0;
        cmd_data = 8'h00;
        rdy_force_hi = 1'b0;
        rdy_force_lo = 1'b0;
        tx_hold = 1'b0;
        const_mode = 1'b0;
        seed = int'($urandom_range(0, 1023));

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 2'b00);
        chk("reset_tx_ready", txr, 2'b00);
        chk("reset_ready_flag", rrf, 2'b11);
        chk("reset_tx_data", txd[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_holds_ready_flag", rrf, 2'b11);

        run_frame(0, 8'h80, 0);
        const_mode = 1'b1;
        run_frame(0, 8'h84, 0);
        const_mode = 1'b0;
        run_frame(1, 8'h81, 0);

        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_data = 8'h41;
        @(negedge clk);
        cmd_data = 8'h7F;
        @(negedge clk);
        cmd_valid = '0;
        @(negedge clk);
        chk("non_start_cmd_ignored", busy[0], 0);
        chk("non_start_cmd_no_strobe", txr[0], 0);

        run_frame(0, 8'h80, 4);
        run_frame(0, 8'h80, 1);
        run_frame(0, 8'h80, 2);
        run_frame(0, 8'h80, 0);
        run_frame(0, 8'h80, 3);
        for (int n = 0; n < 6; n++) begin
            seed = int'($urandom_range(0, 1023));
            run_frame(int'($urandom_range(0, 1)), 8'h80 | 8'($urandom_range(0, 7)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
